// File: rtl/fetch_if.sv
// Instruction-memory request/response bundle between the fetch unit and memory.
interface fetch_if;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i;
   logic [31:0] imem_addr_o;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;

   modport master (
      output imem_req_valid_o,
      output imem_addr_o,
      input  imem_req_ready_i,
      input  imem_rsp_valid_i,
      input  imem_rsp_data_i
   );

   modport slave (
      input  imem_req_valid_o,
      input  imem_addr_o,
      output imem_req_ready_i,
      output imem_rsp_valid_i,
      output imem_rsp_data_i
   );
endinterface

// File: rtl/fetch.sv
// Instruction fetch unit: issues sequential word fetches, tracks in-flight
// requests, buffers returned words in a 2-entry FIFO for decode and squashes
// stale responses after a redirect.
module fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   fetch_if.master     imem,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        stall_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] rsp_pc_q, rsp_pc_d;
   logic [1:0]  out_q, out_d;
   logic [1:0]  disc_q, disc_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        head_q, head_d;
   logic [31:0] buf_instr_q [2];
   logic [31:0] buf_pc_q    [2];

   logic        redir_act;
   logic        req_valid;
   logic        xfer;
   logic        rsp_ok;
   logic        push;
   logic        pop;
   logic        tail;
   logic [1:0]  out_nxt;
   logic [31:0] redir_tgt;

   // Handshake qualifiers: credit check keeps in-flight + buffered words within the 2 slots
   always_comb begin
      redir_act = redirect_i && (state_q != ST_IDLE);
      req_valid = (state_q == ST_FETCH) && !redirect_i &&
                  (({1'b0, out_q} + {1'b0, cnt_q}) < 3'd2);
      xfer      = req_valid && imem.imem_req_ready_i;
      // a response with nothing outstanding is a protocol error and is ignored
      rsp_ok    = imem.imem_rsp_valid_i && (out_q != 2'd0);
      push      = rsp_ok && (state_q == ST_FETCH) && !redirect_i;
      pop       = (cnt_q != 2'd0) && !stall_i;
      tail      = head_q ^ cnt_q[0];
      out_nxt   = out_q + {1'b0, xfer} - {1'b0, rsp_ok};
      redir_tgt = redirect_pc_i & 32'hFFFF_FFFC;
   end

   // Next-state logic: redirect overrides everything, otherwise FSM step plus FIFO update
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      out_d      = out_nxt;
      disc_d     = disc_q;
      cnt_d      = cnt_q;
      head_d     = head_q;
      if (redir_act) begin
         // everything still in flight after this cycle belongs to the old path
         state_d    = (out_nxt != 2'd0) ? ST_FLUSH : ST_FETCH;
         disc_d     = out_nxt;
         fetch_pc_d = redir_tgt;
         rsp_pc_d   = redir_tgt;
         cnt_d      = 2'd0;
         head_d     = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: state_d = ST_FETCH;
            ST_FLUSH: begin
               if (rsp_ok) begin
                  disc_d = disc_q - 2'd1;
                  if (disc_q == 2'd1) state_d = ST_FETCH;
               end
            end
            default:  state_d = ST_IDLE;
         endcase
         if (xfer) fetch_pc_d = fetch_pc_q + 32'd4;
         if (push) rsp_pc_d = rsp_pc_q + 32'd4;
         cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
         head_d = head_q ^ pop;
      end
   end

   // State, counters and instruction buffer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         fetch_pc_q     <= RESET_PC;
         rsp_pc_q       <= RESET_PC;
         out_q          <= 2'd0;
         disc_q         <= 2'd0;
         cnt_q          <= 2'd0;
         head_q         <= 1'b0;
         buf_instr_q[0] <= 32'd0;
         buf_instr_q[1] <= 32'd0;
         buf_pc_q[0]    <= 32'd0;
         buf_pc_q[1]    <= 32'd0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         out_q      <= out_d;
         disc_q     <= disc_d;
         cnt_q      <= cnt_d;
         head_q     <= head_d;
         if (push) begin
            buf_instr_q[tail] <= imem.imem_rsp_data_i;
            buf_pc_q[tail]    <= rsp_pc_q;
         end
      end
   end

   assign imem.imem_req_valid_o = req_valid;
   assign imem.imem_addr_o      = fetch_pc_q;
   assign instr_valid_o         = (cnt_q != 2'd0);
   assign instr_o               = buf_instr_q[head_q];
   assign pc_o                  = buf_pc_q[head_q];

endmodule
